// File: rtl/d_pipe_reg_pkg.sv
// Shared definitions for the elastic D-register pipeline.
// A stage record is packed as {valid, data}, with the valid bit at the MSB.
package d_pipe_reg_pkg;

    // Width of the occupancy counter that must hold every value from 0 to depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of one packed stage record {valid, data}.
    function automatic int stage_bits(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/d_pipe_reg_if.sv
// Handshake bus of the pipeline: producer side (IN_*, D) and consumer side (OUT_*, Q), plus occupancy.
interface d_pipe_reg_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) ();
    import d_pipe_reg_pkg::*;

    localparam int CW = count_width(DEPTH);

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] D;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] Q;
    logic [CW-1:0]    COUNT;

    // Environment view: drives the producer word and the consumer ready.
    modport master (
        output IN_VALID, D, OUT_READY,
        input  IN_READY, OUT_VALID, Q, COUNT
    );

    // Pipeline view.
    modport slave (
        input  IN_VALID, D, OUT_READY,
        output IN_READY, OUT_VALID, Q, COUNT
    );
endinterface

// File: rtl/d_pipe_reg_stage.sv
// One register stage of the pipeline: holds a {valid, data} record.
// The stage loads its upstream record when allowed to advance; data only changes
// when a valid word arrives, so an empty stage keeps its old data stable.
module d_pipe_stage
    import d_pipe_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             adv,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    localparam int SB = stage_bits(WIDTH);

    logic [SB-1:0] stage_q;
    logic [SB-1:0] stage_d;

    // Next record: advance from upstream, hold otherwise; flush empties the stage without touching data.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d[WIDTH] = 1'b0;
        end else if (adv) begin
            stage_d[WIDTH] = up_valid;
            if (up_valid) begin
                stage_d[WIDTH-1:0] = up_data;
            end
        end
    end

    // Stage register with synchronous reset clearing both valid and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid = stage_q[WIDTH];
    assign data  = stage_q[WIDTH-1:0];
endmodule

// File: rtl/d_pipe_reg.sv
// Elastic pipeline of DEPTH register stages with valid/ready at both ends,
// synchronous flush and a registered occupancy count. Ready ripples
// combinationally from the consumer back to the producer.
module d_pipe_reg
    import d_pipe_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input logic         CK,
    input logic         RST,
    input logic         FLUSH,
    d_pipe_reg_if.slave bus
);
    localparam int CW = count_width(DEPTH);

    logic             stage_valid [DEPTH];
    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic             adv         [DEPTH];
    logic             in_ready;
    logic             in_xfer;
    logic             out_xfer;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Advance chain: a stage may move when it is empty or the stage downstream moves.
    always_comb begin
        adv[DEPTH-1] = ~stage_valid[DEPTH-1] | bus.OUT_READY;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = ~stage_valid[i] | adv[i+1];
        end
    end

    assign in_ready = adv[0] & ~FLUSH;
    assign in_xfer  = bus.IN_VALID & in_ready;
    assign out_xfer = stage_valid[DEPTH-1] & bus.OUT_READY;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic             up_valid;
            logic [WIDTH-1:0] up_data;

            if (i == 0) begin : g_head
                assign up_valid = in_xfer;
                assign up_data  = bus.D;
            end else begin : g_body
                assign up_valid = stage_valid[i-1];
                assign up_data  = stage_data[i-1];
            end

            d_pipe_stage #(
                .WIDTH(WIDTH)
            ) u_stage (
                .clk     (CK),
                .rst     (RST),
                .flush   (FLUSH),
                .adv     (adv[i]),
                .up_valid(up_valid),
                .up_data (up_data),
                .valid   (stage_valid[i]),
                .data    (stage_data[i])
            );
        end
    endgenerate

    // Occupancy tracks accepted minus delivered words; flush empties the pipe.
    always_comb begin
        count_d = count_q;
        if (FLUSH) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CW'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    // Occupancy register with synchronous reset.
    always_ff @(posedge CK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = stage_valid[DEPTH-1];
    assign bus.Q         = stage_data[DEPTH-1];
    assign bus.COUNT     = count_q;
endmodule

// File: tb/tb_d_pipe_reg.sv
// Directed bench for d_pipe_reg with WIDTH=8, DEPTH=3.
module tb_d_pipe_reg;
    logic CK;
    logic RST;
    logic FLUSH;
    int   checks;
    int   errors;

    d_pipe_reg_if #(.WIDTH(8), .DEPTH(3)) bus ();

    d_pipe_reg #(
        .WIDTH(8),
        .DEPTH(3)
    ) dut (
        .CK   (CK),
        .RST  (RST),
        .FLUSH(FLUSH),
        .bus  (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    // Drive all inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic rst, input logic flush, input logic iv,
                                 input logic [7:0] d, input logic ordy);
        RST           = rst;
        FLUSH         = flush;
        bus.IN_VALID  = iv;
        bus.D         = d;
        bus.OUT_READY = ordy;
        #1;
    endtask

    // Advance over one rising edge and park on the falling edge.
    task automatic clockEdge();
        @(posedge CK);
        @(negedge CK);
    endtask

    // Count one comparison and report it if it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Check the registered outputs in one call.
    task automatic checkState(input string tag, input logic ov, input logic [7:0] q,
                              input logic [1:0] cnt);
        checkOutput({tag, ".ov"}, 32'(bus.OUT_VALID), 32'(ov));
        if (ov) checkOutput({tag, ".q"}, 32'(bus.Q), 32'(q));
        checkOutput({tag, ".cnt"}, 32'(bus.COUNT), 32'(cnt));
    endtask

    // Safety net in case the sequence never completes.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;

        // Reset held two cycles while a word is offered.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
        clockEdge();
        clockEdge();
        checkOutput("rst.ov", 32'(bus.OUT_VALID), 32'h0);
        checkOutput("rst.q", 32'(bus.Q), 32'h00);
        checkOutput("rst.cnt", 32'(bus.COUNT), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
        checkOutput("rst.rdy", 32'(bus.IN_READY), 32'h1);
        clockEdge();
        checkState("rst.after", 1'b0, 8'h00, 2'd0);

        // Streaming with the consumer always ready.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 1'b1);
        checkOutput("str.rdy0", 32'(bus.IN_READY), 32'h1);
        clockEdge();
        checkState("str.e0", 1'b0, 8'h00, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h02, 1'b1);
        clockEdge();
        checkState("str.e1", 1'b0, 8'h00, 2'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h03, 1'b1);
        clockEdge();
        checkState("str.e2", 1'b1, 8'h01, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h04, 1'b1);
        checkOutput("str.rdy3", 32'(bus.IN_READY), 32'h1);
        clockEdge();
        checkState("str.e3", 1'b1, 8'h02, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        clockEdge();
        checkState("str.e4", 1'b1, 8'h03, 2'd2);
        clockEdge();
        checkState("str.e5", 1'b1, 8'h04, 2'd1);
        clockEdge();
        checkState("str.e6", 1'b0, 8'h00, 2'd0);

        // Backpressure: consumer stalled while four words are offered.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA3, 1'b0);
        checkOutput("bp.rdyA3", 32'(bus.IN_READY), 32'h1);
        clockEdge();
        checkState("bp.full", 1'b1, 8'hA1, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA4, 1'b0);
        checkOutput("bp.rdyA4", 32'(bus.IN_READY), 32'h0);
        clockEdge();
        checkState("bp.hold", 1'b1, 8'hA1, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA4, 1'b1);
        checkOutput("bp.rdyRel", 32'(bus.IN_READY), 32'h1);
        clockEdge();
        checkState("bp.outA2", 1'b1, 8'hA2, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        clockEdge();
        checkState("bp.outA3", 1'b1, 8'hA3, 2'd2);
        clockEdge();
        checkState("bp.outA4", 1'b1, 8'hA4, 2'd1);
        clockEdge();
        checkState("bp.empty", 1'b0, 8'h00, 2'd0);

        // Full pass-through: fill, then stream in and out together.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hB1, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hB2, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hB3, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hB4, 1'b1);
        checkOutput("pt.rdyB4", 32'(bus.IN_READY), 32'h1);
        clockEdge();
        checkState("pt.B2", 1'b1, 8'hB2, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hB5, 1'b1);
        checkOutput("pt.rdyB5", 32'(bus.IN_READY), 32'h1);
        clockEdge();
        checkState("pt.B3", 1'b1, 8'hB3, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        clockEdge();
        checkState("pt.B4", 1'b1, 8'hB4, 2'd2);

        // Flush with two words held and a word offered.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0);
        checkOutput("fl.rdy", 32'(bus.IN_READY), 32'h0);
        clockEdge();
        checkState("fl.e0", 1'b0, 8'h00, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            clockEdge();
            checkState("fl.quiet", 1'b0, 8'h00, 2'd0);
        end

        // Reset while full and stalled, then a single word afterwards.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hC2, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hC3, 1'b0);
        clockEdge();
        checkState("mr.full", 1'b1, 8'hC1, 2'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        clockEdge();
        checkOutput("mr.ov", 32'(bus.OUT_VALID), 32'h0);
        checkOutput("mr.q", 32'(bus.Q), 32'h00);
        checkOutput("mr.cnt", 32'(bus.COUNT), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hD7, 1'b1);
        checkOutput("mr.rdy", 32'(bus.IN_READY), 32'h1);
        clockEdge();
        checkState("mr.e0", 1'b0, 8'h00, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        clockEdge();
        checkState("mr.e1", 1'b0, 8'h00, 2'd1);
        clockEdge();
        checkState("mr.e2", 1'b1, 8'hD7, 2'd1);
        clockEdge();
        checkState("mr.e3", 1'b0, 8'h00, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
